// File: rtl/riscv_hazard_scoreboard.sv
// Tracks in-flight destination registers after ID and derives forwarding selects,
// load-use stalls and a saturating stall counter for a simple in-order RISC-V pipe.
module riscv_hazard_scoreboard #(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 16,
  localparam int SELW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             kill,
  output logic             stall,
  output logic [SELW-1:0]  fwd_rs1_sel,
  output logic [SELW-1:0]  fwd_rs2_sel,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DEPTH:1] st_valid;
  logic [DEPTH:1] st_we;
  logic [DEPTH:1] st_load;
  logic [4:0]     st_rd [1:DEPTH];

  logic hz_rs1;
  logic hz_rs2;
  logic accept;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_rs1_sel = '0;
    fwd_rs2_sel = '0;
    hz_rs1      = 1'b0;
    hz_rs2      = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_use_rs1 && st_valid[k] && st_we[k] && (st_rd[k] == id_rs1) && (id_rs1 != 5'd0)) begin
        fwd_rs1_sel = SELW'(k);
        hz_rs1      = st_load[k] && (k < LOAD_STAGE);
      end
      if (id_use_rs2 && st_valid[k] && st_we[k] && (st_rd[k] == id_rs2) && (id_rs2 != 5'd0)) begin
        fwd_rs2_sel = SELW'(k);
        hz_rs2      = st_load[k] && (k < LOAD_STAGE);
      end
    end
  end

  assign stall  = id_valid && !flush && !kill && (hz_rs1 || hz_rs2);
  assign accept = id_valid && !stall && !flush && !kill;
  assign busy   = |st_valid;

  // Stages keep advancing during a stall; the stalled instruction becomes a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_valid <= '0;
      st_we    <= '0;
      st_load  <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        st_rd[k] <= 5'd0;
      end
    end else if (kill) begin
      st_valid <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        st_valid[k] <= st_valid[k-1];
        st_we[k]    <= st_we[k-1];
        st_load[k]  <= st_load[k-1];
        st_rd[k]    <= st_rd[k-1];
      end
      st_valid[1] <= accept;
      st_we[1]    <= id_we;
      st_load[1]  <= id_is_load;
      st_rd[1]    <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed bench for riscv_hazard_scoreboard: a default instance and a CNT_W=4
// instance share stimulus so counter saturation can be observed quickly.
module tb_riscv_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_we, id_is_load;
  logic       flush, kill;

  logic        stall, busy, stall4, busy4;
  logic [1:0]  fwd1, fwd2, fwd1_4, fwd2_4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush), .kill(kill),
    .stall(stall), .fwd_rs1_sel(fwd1), .fwd_rs2_sel(fwd2), .busy(busy), .stall_cnt(cnt)
  );

  riscv_hazard_scoreboard #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush), .kill(kill),
    .stall(stall4), .fwd_rs1_sel(fwd1_4), .fwd_rs2_sel(fwd2_4), .busy(busy4), .stall_cnt(cnt4)
  );

  task automatic check_output(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                                input logic u1, input logic u2, input logic [4:0] d,
                                input logic w, input logic ld);
    id_valid   = v;
    id_rs1     = r1;
    id_rs2     = r2;
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_rd      = d;
    id_we      = w;
    id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic check_comb(input string tag, input int exp_stall, input int exp_f1, input int exp_f2);
    check_output({tag, ".stall"}, int'(stall), exp_stall);
    check_output({tag, ".fwd1"}, int'(fwd1), exp_f1);
    check_output({tag, ".fwd2"}, int'(fwd2), exp_f2);
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    kill    = 1'b0;
    idle();
    #1;
    check_output("rst.busy", int'(busy), 0);
    check_output("rst.cnt", int'(cnt), 0);
    check_comb("rst", 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check_output("post_rst.busy", int'(busy), 0);
    check_output("post_rst.cnt", int'(cnt), 0);

    // add x5; add x6,x5,x0; user of x5 two stages later
    apply_stimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    check_comb("add5", 0, 0, 0);
    tick();
    apply_stimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    check_comb("dep_ex", 0, 1, 0);
    tick();
    apply_stimulus(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    check_comb("dep_mem", 0, 2, 0);
    tick();
    idle();
    tick();
    check_output("drain.busy1", int'(busy), 1);
    tick();
    tick();
    check_output("drain.busy0", int'(busy), 0);

    // load x7 then immediate user: one stall cycle, then forward from stage 2
    apply_stimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);
    tick();
    apply_stimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    check_comb("ldu", 1, 1, 0);
    tick();
    check_output("ldu.cnt", int'(cnt), 1);
    check_output("ldu.cnt4", int'(cnt4), 1);
    check_comb("ldu_after", 0, 2, 0);
    tick();
    drain();
    check_output("ldu.cnt_hold", int'(cnt), 1);

    // load x8, add x8, user of x8: youngest non-load wins, no stall
    apply_stimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    apply_stimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    apply_stimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    check_comb("youngest", 0, 1, 1);
    tick();
    drain();

    // load writing x0 must never match; unused rs2 never forwards
    apply_stimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    apply_stimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    check_comb("x0", 0, 0, 0);
    tick();
    apply_stimulus(1'b1, 5'd1, 5'd13, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0);
    check_comb("rs2_unused", 0, 0, 0);
    apply_stimulus(1'b1, 5'd1, 5'd13, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    check_comb("rs2_used", 0, 0, 1);
    tick();
    drain();

    // fill all stages then kill
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'(20 + i), 1'b1, 1'b0);
      tick();
    end
    check_output("fill.busy", int'(busy), 1);
    kill = 1'b1;
    apply_stimulus(1'b1, 5'd22, 5'd0, 1'b1, 1'b0, 5'd23, 1'b1, 1'b0);
    check_output("kill.stall", int'(stall), 0);
    tick();
    kill = 1'b0;
    check_output("kill.busy", int'(busy), 0);
    apply_stimulus(1'b1, 5'd22, 5'd23, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
    check_comb("kill_after", 0, 0, 0);

    // flush alone: bubble in stage 1, older entries keep shifting
    apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0);
    tick();
    flush = 1'b1;
    apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    apply_stimulus(1'b1, 5'd16, 5'd15, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    check_comb("flush", 0, 2, 0);
    drain();

    // own rd equal to own source sees only prior entries
    apply_stimulus(1'b1, 5'd17, 5'd0, 1'b1, 1'b0, 5'd17, 1'b1, 1'b0);
    check_comb("self", 0, 0, 0);
    tick();
    apply_stimulus(1'b1, 5'd17, 5'd0, 1'b1, 1'b0, 5'd18, 1'b1, 1'b0);
    check_comb("self_next", 0, 1, 0);
    tick();
    drain();

    // repeated load-use on x20 stalls every other cycle: 20 stalls in 40 cycles
    apply_stimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b1);
    tick();
    apply_stimulus(1'b1, 5'd20, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      check_output($sformatf("sat.stall%0d", i), int'(stall4), (i % 2 == 0) ? 1 : 0);
      tick();
    end
    check_output("sat.cnt4", int'(cnt4), 15);
    check_output("sat.cnt16", int'(cnt), 21);
    check_output("sat.busy", int'(busy), 1);

    // asynchronous reset pulse away from any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check_output("arst.cnt", int'(cnt), 0);
    check_output("arst.cnt4", int'(cnt4), 0);
    check_output("arst.busy", int'(busy), 0);
    reset_n = 1'b1;
    #1;
    check_comb("arst_after", 0, 0, 0);
    tick();
    check_output("arst.busy_next", int'(busy), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
